bus_xfer_ctrl: RTL

Register-transfer sequencer for the 16-bit microcontroller's shared data bus. It sits directly upstream of the general-purpose register file. On request, it drives the per-register tri-state output enables and load enables so that one register's value is placed on the bus and captured by another. Its sequencing guarantees that exactly one bus driver is active, and that a load happens only while the bus is stable.

---
 rtl/bus_xfer_ctrl.sv | 58 +++++
 1 files changed

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences one register-to-register move over the shared data bus
module bus_xfer_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SEL_W-1:0]    src_sel,
    input  logic [SEL_W-1:0]    dst_sel,
    output logic                ready,
    output logic                done,
    output logic                err,
    output logic [NUM_REGS-1:0] reg_out_tri_en,
    output logic [NUM_REGS-1:0] reg_en,
    output logic [CNT_W-1:0]    xfer_count
);
    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, RELEASE} state_t;
    state_t           state, state_n;
    logic [SEL_W-1:0] src_q, dst_q, src_n, dst_n;
    logic             acc, bad, noop;
    // accept decode and next state; selects are taken live only at acceptance
    always_comb begin
        acc     = ready && start;
        bad     = int'(src_sel) >= NUM_REGS || int'(dst_sel) >= NUM_REGS;
        noop    = src_sel == dst_sel;
        src_n   = acc ? src_sel : src_q;
        dst_n   = acc ? dst_sel : dst_q;
        state_n = state == DRIVE ? LOAD :
                  state == LOAD  ? RELEASE :
                  (acc && !bad && !noop) ? DRIVE : IDLE;
    end
    // state and registered outputs, all decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            ready          <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            reg_out_tri_en <= '0;
            reg_en         <= '0;
            xfer_count     <= '0;
        end else begin
            state          <= state_n;
            src_q          <= src_n;
            dst_q          <= dst_n;
            ready          <= state_n == IDLE || state_n == RELEASE;
            done           <= state_n == RELEASE || (acc && (bad || noop));
            err            <= acc && bad;
            reg_out_tri_en <= (state_n == DRIVE || state_n == LOAD) ? NUM_REGS'(1) << src_n : '0;
            reg_en         <= state_n == LOAD ? NUM_REGS'(1) << dst_n : '0;
            xfer_count     <= xfer_count + CNT_W'(state_n == RELEASE);
        end
    end
endmodule
